// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for a shared 1-bit ALU slice: latches an operation, walks
// the operands LSB first through the external slice and assembles result and flags.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [1:0]       slice_op,
  input  logic             slice_out,
  input  logic             slice_cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [2:0]       op_q;
  logic             carry_ff;
  logic [CNT_W-1:0] bit_cnt;
  logic             legal, accept, last, is_sub, is_arith;
  logic [WIDTH-1:0] res_final;

  assign legal     = (op <= OP_SUB);
  assign accept    = (state != RUN) && start && legal;
  assign last      = (state == RUN) && (bit_cnt == LAST_BIT);
  assign is_sub    = (op_q == OP_SUB);
  assign is_arith  = (op_q == OP_ADD) || is_sub;
  assign res_final = {slice_out, res_sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    slice_a   = 1'b0;
    slice_b   = 1'b0;
    slice_cin = 1'b0;
    slice_op  = 2'b00;
    if (state == RUN) begin
      slice_a   = a_sh[0];
      slice_b   = is_sub ? ~b_sh[0] : b_sh[0];
      slice_cin = carry_ff;
      slice_op  = is_sub ? 2'b11 : op_q[1:0];
    end
  end

  // Control and flag registers; the SUB carry seed of 1 supplies the +1 of A + ~B + 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_ff  <= 1'b0;
      bit_cnt   <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      carry_ff <= (op == OP_SUB);
      bit_cnt  <= '0;
    end else if (state == RUN) begin
      if (is_arith) carry_ff <= slice_cout;
      if (last) begin
        result    <= res_final;
        carry_out <= is_arith ? slice_cout : 1'b0;
        zero      <= (res_final == '0);
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Operand and partial-result shifters carry no reset; they are only observed in RUN.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
      op_q <= op;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_final;
    end
  end

endmodule
